modmul_arbiter: RTL and testbench

MODMUL_ARBITER -- requirements
Module: modmul_arbiter

---
 rtl/rsa_pkg.sv | 18 +
 rtl/rr_pick2.sv | 17 +
 rtl/modmul_arbiter.sv | 122 ++++++++++++
 tb/tb_modmul_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
`default_nettype none
// rsa_pkg: shared operand width, product width and FSM state encoding (rev 1.0).
package rsa_pkg;

  localparam int W_DEFAULT      = 128;
  localparam int PROD_W_DEFAULT = 2 * W_DEFAULT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// rr_pick2: two-way round-robin picker; the requester not served last wins a tie (rev 1.0).
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/modmul_arbiter.sv
`default_nettype none
// modmul_arbiter: arbitrates two requesters onto a shared multiplier and divider
// to compute (a*b) mod n (rev 1.0).
module modmul_arbiter
  import rsa_pkg::*;
#(
  parameter  int W  = W_DEFAULT,
  localparam int PW = prod_width(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [W-1:0]  a0,
  input  logic [W-1:0]  b0,
  input  logic [W-1:0]  n0,
  input  logic [W-1:0]  a1,
  input  logic [W-1:0]  b1,
  input  logic [W-1:0]  n1,
  output logic          ack0,
  output logic          ack1,
  output logic [W-1:0]  result,
  output logic          err,
  output logic          busy,
  output logic          mult_rst_n,
  output logic [W-1:0]  mult_a,
  output logic [W-1:0]  mult_b,
  input  logic          mult_done,
  input  logic [PW-1:0] prod,
  output logic          div_rst_n,
  output logic [PW-1:0] div_a,
  output logic [W-1:0]  div_b,
  input  logic          div_done,
  input  logic [W-1:0]  remainder
);

  logic [1:0]    state;
  logic [W-1:0]  a_q, b_q, n_q, result_q;
  logic [PW-1:0] prod_q;
  logic          err_q;
  logic          id_q;
  logic          prio;
  logic [1:0]    grant;
  logic          pick1;
  logic [W-1:0]  sel_a, sel_b, sel_n;

  // prio names the requester that wins a tie; the picker wants the last-served one.
  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (~prio),
    .grant (grant)
  );

  assign pick1 = grant[1];
  assign sel_a = pick1 ? a1 : a0;
  assign sel_b = pick1 ? b1 : b0;
  assign sel_n = pick1 ? n1 : n0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      prod_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      id_q     <= 1'b0;
      prio     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            id_q <= pick1;
            prio <= ~pick1;
            a_q  <= sel_a;
            b_q  <= sel_b;
            n_q  <= sel_n;
            // A zero modulus never touches the arithmetic units.
            if (sel_n == '0) begin
              result_q <= '0;
              err_q    <= 1'b1;
              state    <= S_RESP;
            end else begin
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (mult_done) begin
            prod_q <= prod;
            state  <= S_DIV;
          end
        end
        S_DIV: begin
          if (div_done) begin
            result_q <= remainder;
            err_q    <= 1'b0;
            state    <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Unit controls decode straight from state so an async reset releases them at once.
  assign busy       = (state != S_IDLE);
  assign mult_rst_n = (state == S_MUL);
  assign div_rst_n  = (state == S_DIV);
  assign ack0       = (state == S_RESP) && !id_q;
  assign ack1       = (state == S_RESP) &&  id_q;
  assign mult_a     = a_q;
  assign mult_b     = b_q;
  assign div_a      = prod_q;
  assign div_b      = n_q;
  assign result     = result_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_modmul_arbiter.sv
`default_nettype none
// tb_modmul_arbiter: scoreboard bench with behavioural multiplier/divider units and a modmul reference.
module tb_modmul_arbiter;

  localparam int W  = 128;
  localparam int PW = 2 * W;

  logic          clk, reset, req0, req1;
  logic [W-1:0]  a0, b0, n0, a1, b1, n1;
  logic          ack0, ack1, err, busy;
  logic [W-1:0]  result;
  logic          mult_rst_n, mult_done, div_rst_n, div_done;
  logic [W-1:0]  mult_a, mult_b, div_b, remainder;
  logic [PW-1:0] prod, div_a, div_full;

  modmul_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .n0(n0), .a1(a1), .b1(b1), .n1(n1),
    .ack0(ack0), .ack1(ack1), .result(result), .err(err), .busy(busy),
    .mult_rst_n(mult_rst_n), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .prod(prod),
    .div_rst_n(div_rst_n), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .remainder(remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural units: done rises lmul/ldiv edges after reset release.
  int lmul, ldiv, mcnt, dcnt;
  always @(posedge clk) begin
    mcnt <= mult_rst_n ? ((mcnt < 1000) ? mcnt + 1 : mcnt) : 0;
    dcnt <= div_rst_n  ? ((dcnt < 1000) ? dcnt + 1 : dcnt) : 0;
  end
  assign mult_done = mult_rst_n && (mcnt >= lmul);
  assign div_done  = div_rst_n  && (dcnt >= ldiv);
  assign prod      = {{W{1'b0}}, mult_a} * {{W{1'b0}}, mult_b};
  assign div_full  = (div_b == '0) ? '0 : (div_a % {{W{1'b0}}, div_b});
  assign remainder = div_full[W-1:0];

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   vectors, miscompares;
  bit   last_served;
  bit   mult_seen;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] n);
    logic [PW-1:0] p, r;
    if (n == '0) return '0;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r = p % {{W{1'b0}}, n};
    return r[W-1:0];
  endfunction

  always @(mult_rst_n) if (mult_rst_n) mult_seen = 1'b1;

  // Monitor: every ack pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (ack0 || ack1)) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {254'b0, ack1, ack0}, '0);
      end else begin
        e = sb.pop_front();
        check("ack_id", {254'b0, ack1, ack0}, e.id ? 2'b10 : 2'b01);
        check("result", result, e.res);
        check("err", err, e.err);
      end
    end
  end

  // Raise requests, predict service order from the round-robin rule, and wait for the acks.
  task automatic issue(input bit do0, input bit do1,
                       input logic [W-1:0] a0v, input logic [W-1:0] b0v, input logic [W-1:0] n0v,
                       input logic [W-1:0] a1v, input logic [W-1:0] b1v, input logic [W-1:0] n1v,
                       input int reps, input bit early, output int lat);
    int tgt0, tgt1, got0, got1, cyc, budget;
    exp_t e;
    tgt0 = do0 ? reps : 0;
    tgt1 = do1 ? reps : 0;
    got0 = 0; got1 = 0; cyc = 0; lat = -1;
    for (int k = 0; k < tgt0 + tgt1; k++) begin
      if (do0 && do1) e.id = ~last_served;
      else            e.id = do1;
      e.res = e.id ? ref_mod(a1v, b1v, n1v) : ref_mod(a0v, b0v, n0v);
      e.err = e.id ? (n1v == '0) : (n0v == '0);
      sb.push_back(e);
      last_served = e.id;
    end
    @(negedge clk);
    a0 = a0v; b0 = b0v; n0 = n0v; a1 = a1v; b1 = b1v; n1 = n1v;
    req0 = do0; req1 = do1;
    budget = (tgt0 + tgt1) * (lmul + ldiv + 6) + 10;
    while ((got0 < tgt0 || got1 < tgt1) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (early && busy) begin req0 = 1'b0; req1 = 1'b0; end
      if (ack0) begin got0++; if (lat < 0) lat = cyc; if (got0 >= tgt0) req0 = 1'b0; end
      if (ack1) begin got1++; if (lat < 0) lat = cyc; if (got1 >= tgt1) req1 = 1'b0; end
    end
    if (got0 < tgt0 || got1 < tgt1) begin
      check("ack_timeout", got0 + got1, tgt0 + tgt1);
      req0 = 1'b0; req1 = 1'b0;
      sb.delete();
    end
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [W-1:0] big, ra, rb, rn;
    vectors = 0; miscompares = 0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; n0 = '0; a1 = '0; b1 = '0; n1 = '0;
    lmul = 3; ldiv = 4; last_served = 1'b1; mult_seen = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", {254'b0, ack1, ack0}, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_mult_rst_n", mult_rst_n, 0);
    check("rst_div_rst_n", div_rst_n, 0);
    reset = 1'b0;
    @(negedge clk);

    // Simultaneous requests straight after reset: requester 0 first.
    issue(1, 1, 9, 9, 7, 6, 7, 5, 1, 0, lat);
    check("tie_first_latency", lat, lmul + ldiv + 3);
    check("tie_last_result", result, 2);

    // 7*5 mod 11 with latency and hold check.
    issue(1, 0, 7, 5, 11, 0, 0, 0, 1, 0, lat);
    check("basic_latency", lat, lmul + ldiv + 3);
    repeat (3) @(negedge clk);
    check("basic_result_hold", result, 2);
    check("basic_err_hold", err, 0);

    // Zero modulus: straight to RESP, units untouched.
    mult_seen = 1'b0;
    issue(0, 1, 0, 0, 0, 5, 6, 0, 1, 0, lat);
    check("zero_mod_latency", lat, 1);
    check("zero_mod_mult_idle", mult_seen, 0);
    check("zero_mod_result", result, 0);
    check("zero_mod_err", err, 1);

    // Both held continuously: acks alternate 0,1,0,1.
    issue(1, 1, 13, 17, 19, 100, 200, 33, 2, 0, lat);

    // Reset in the middle of MUL.
    lmul = 10; ldiv = 3;
    @(negedge clk);
    a0 = 3; b0 = 4; n0 = 5; req0 = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_pre_mul", mult_rst_n, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_mult_rst_n", mult_rst_n, 0);
    check("mid_div_rst_n", div_rst_n, 0);
    check("mid_ack", {254'b0, ack1, ack0}, 0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_served = 1'b1;
    repeat (lmul + ldiv + 6) @(negedge clk);
    check("mid_idle_after", busy, 0);
    lmul = 2;
    big = '0; big[W-1] = 1'b1;
    issue(1, 0, big, 2, 3, 0, 0, 0, 1, 0, lat);
    check("big_result", result, 1);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      int mask, reps;
      bit early;
      lmul = $urandom_range(1, 6);
      ldiv = $urandom_range(1, 6);
      mask = $urandom_range(1, 3);
      reps = (mask == 3) ? $urandom_range(1, 2) : 1;
      early = (mask != 3) && ($urandom_range(0, 1) == 1);
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      rn = {$urandom(), $urandom(), $urandom(), $urandom()} >> $urandom_range(0, 124);
      if ($urandom_range(0, 5) == 0) rn = '0;
      if (mask == 3)
        issue(1, 1, ra, rb, rn, rb ^ ra, ra, rn + 1, reps, early, lat);
      else
        issue(mask[0], mask[1], ra, rb, rn, rb, ra ^ rb, rn, reps, early, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
